// File: rtl/vtag_pkg.sv
// vtag_pkg: constants and types for the 32-bit Vandermonde MAC tag checker.
//   CONST_ALPHA_32 : reduction constant for GF(2^32), x^32 = x^22 + x^2 + x + 1
//   LANE_W, LANE_N : accumulator lane width and lane count (4 x 32 = 128 bits)
//   state_t        : checker FSM encoding
package vtag_pkg;

  localparam logic [31:0] CONST_ALPHA_32 = 32'h00400007;
  localparam int LANE_W = 32;
  localparam int LANE_N = 4;
  localparam int ACC_W  = LANE_W * LANE_N;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/gf32_xalpha.sv
// gf32_xalpha: combinational multiply-by-x in GF(2^32).
//   a : input field element
//   y : a * x, reduced by CONST_ALPHA_32 when bit 31 shifts out
module gf32_xalpha
  import vtag_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  output logic [LANE_W-1:0] y
);

  logic [LANE_W-1:0] shifted;

  assign shifted = {a[LANE_W-2:0], 1'b0};
  assign y       = a[LANE_W-1] ? (shifted ^ CONST_ALPHA_32) : shifted;

endmodule

// File: rtl/v_tag_verify_32.sv
// v_tag_verify_32: receiver-side tag checker for the 32-bit Vandermonde MAC.
// Absorbs 32-bit PDP words, updates a 4-lane Horner accumulator (lane i is
// multiplied by alpha^i per beat, then the word is XORed in), and after the
// last word compares the accumulator against the received tag.
//
// Ports:
//   clk, rst         : clock (rising edge), asynchronous active-high reset
//   start            : one-cycle pulse, clears state and (re)enters ABSORB
//   in_valid/in_ready: input handshake; in_data/in_last qualify the beat
//   tag_exp          : received tag, sampled in CHECK
//   busy             : high in ABSORB or CHECK
//   done             : one-cycle verdict strobe
//   tag_ok           : verdict, held until the next start
//   tag_acc          : live accumulator, lane i = bits [32i+31:32i]
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on the FSM state, never on in_valid, and in_data /
// in_last are only looked at on a transferring edge.
//
// Build option: define VTAG_ZEROIZE_EN to clear the accumulator in the DONE
// cycle whenever the verdict is a failure.
module v_tag_verify_32
  import vtag_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANE_W-1:0]  in_data,
  input  logic               in_last,
  input  logic [ACC_W-1:0]   tag_exp,
  output logic               busy,
  output logic               done,
  output logic               tag_ok,
  output logic [ACC_W-1:0]   tag_acc
);

  state_t state, state_nx;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_upd;
  logic [LANE_W-1:0] l1_x1;
  logic [LANE_W-1:0] l2_x1, l2_x2;
  logic [LANE_W-1:0] l3_x1, l3_x2, l3_x3;
  logic              beat;

  // Lane multipliers: lane i needs alpha^i, built from chained x-alpha stages.
  gf32_xalpha u_l1_a (.a(acc[2*LANE_W-1:LANE_W]),   .y(l1_x1));

  gf32_xalpha u_l2_a (.a(acc[3*LANE_W-1:2*LANE_W]), .y(l2_x1));
  gf32_xalpha u_l2_b (.a(l2_x1),                    .y(l2_x2));

  gf32_xalpha u_l3_a (.a(acc[4*LANE_W-1:3*LANE_W]), .y(l3_x1));
  gf32_xalpha u_l3_b (.a(l3_x1),                    .y(l3_x2));
  gf32_xalpha u_l3_c (.a(l3_x2),                    .y(l3_x3));

  assign acc_upd = {l3_x3 ^ in_data,
                    l2_x2 ^ in_data,
                    l1_x1 ^ in_data,
                    acc[LANE_W-1:0] ^ in_data};

  assign beat = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; start overrides everything, including an abort of a
  // stream in flight (the beat presented with start is dropped).
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = ABSORB;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        ABSORB:  if (beat && in_last) state_nx = CHECK;
        CHECK:   state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ABSORB: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      CHECK:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (start) begin
      acc <= '0;
    end else if (beat) begin
      acc <= acc_upd;
`ifdef VTAG_ZEROIZE_EN
    end else if (state == DONE && !tag_ok) begin
      // Never leave the computed tag of a failed check visible.
      acc <= '0;
`endif
    end
  end

  // Verdict: full-width equality in one cycle, held until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_ok <= 1'b0;
    end else if (start) begin
      tag_ok <= 1'b0;
    end else if (state == CHECK) begin
      tag_ok <= (acc == tag_exp);
    end
  end

  assign tag_acc = acc;

endmodule

// File: tb/tb_v_tag_verify_32.sv
// tb_v_tag_verify_32: self-checking bench for v_tag_verify_32.
// Table of streams plus hand-written abort / reset sequences; expected
// verdicts are queued when a stream is driven and popped at done.
module tb_v_tag_verify_32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [127:0] tag_exp;
  logic         busy;
  logic         done;
  logic         tag_ok;
  logic [127:0] tag_acc;

  v_tag_verify_32 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .tag_exp  (tag_exp),
    .busy     (busy),
    .done     (done),
    .tag_ok   (tag_ok),
    .tag_acc  (tag_acc)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;

  logic [127:0] exp_acc_q[$];
  logic         exp_ok_q[$];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] xa(input logic [31:0] v);
    logic [31:0] s;
    s = {v[30:0], 1'b0};
    return v[31] ? (s ^ 32'h00400007) : s;
  endfunction

  function automatic logic [127:0] model(input logic [31:0] w[8], input int n);
    logic [31:0] a0, a1, a2, a3;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int k = 0; k < n; k++) begin
      a0 = a0 ^ w[k];
      a1 = xa(a1) ^ w[k];
      a2 = xa(xa(a2)) ^ w[k];
      a3 = xa(xa(xa(a3))) ^ w[k];
    end
    return {a3, a2, a1, a0};
  endfunction

  // ---------------- stimulus table ----------------
  typedef struct {
    int           n;
    logic [31:0]  w [8];
    logic [127:0] tag;
    logic [127:0] acc;
    logic         ok;
    logic         gaps;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  // ---------------- driver tasks ----------------
  task automatic drive_stream(input logic [31:0] w[8], input int n,
                              input logic gaps, input logic [127:0] tag);
    int   i;
    int   budget;
    logic rdy;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; in_last = 1'b0; tag_exp = tag;
    @(negedge clk);
    start = 1'b0;
    i = 0; budget = 0;
    while (i < n && budget < 200) begin
      if (gaps && $urandom_range(0, 1) == 0) begin
        // idle cycle; in_last without in_valid must be ignored
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b1;
        in_data  = w[i];
        in_last  = (i == n - 1);
      end
      rdy = in_ready;
      @(negedge clk);
      if (in_valid && rdy) i++;
      budget++;
    end
    chk("stream_accept", 128'(i), 128'(n));
    // keep presenting junk after the last beat; it must be ignored
    in_valid = 1'b1;
    in_data  = 32'hdeadbeef;
    in_last  = 1'b1;
  endtask

  task automatic wait_verdict(input string name);
    int           cyc;
    logic [127:0] ea;
    logic         eo;
    logic [127:0] ea_after;
    cyc = 0;
    ea  = '0;
    eo  = 1'b0;
    // now in CHECK
    chk1({name, "_check_ready"}, in_ready, 1'b0);
    chk1({name, "_check_busy"}, busy, 1'b1);
    while (done !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_latency"}, 128'(cyc), 128'(1));
    if (exp_acc_q.size() > 0) begin
      ea = exp_acc_q.pop_front();
      eo = exp_ok_q.pop_front();
    end
    chk1({name, "_tag_ok"}, tag_ok, eo);
    chk({name, "_tag_acc"}, tag_acc, ea);
    chk1({name, "_done_ready"}, in_ready, 1'b0);
    @(negedge clk);
    chk1({name, "_done_width"}, done, 1'b0);
    chk1({name, "_idle_busy"}, busy, 1'b0);
    chk1({name, "_idle_ready"}, in_ready, 1'b0);
    chk1({name, "_tag_ok_held"}, tag_ok, eo);
`ifdef VTAG_ZEROIZE_EN
    ea_after = eo ? ea : 128'h0;
`else
    ea_after = ea;
`endif
    chk({name, "_acc_after"}, tag_acc, ea_after);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // ---------------- test ----------------
  logic [31:0]  rw [8];
  logic [31:0]  one_w [8];
  logic [127:0] pattern_one;
  int           d0;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; tag_exp = '0;
    pattern_one = 128'h00000001_00000001_00000001_00000001;

    for (int k = 0; k < 8; k++) begin
      rw[k]    = $urandom;
      one_w[k] = '0;
    end
    one_w[0] = 32'h1;

    for (int v = 0; v < NV; v++) begin
      vecs[v].n = 0; vecs[v].tag = '0; vecs[v].acc = '0;
      vecs[v].ok = 1'b0; vecs[v].gaps = 1'b0;
      for (int k = 0; k < 8; k++) vecs[v].w[k] = '0;
    end
    // single word
    vecs[0].n = 1; vecs[0].w[0] = 32'h00000001;
    vecs[0].tag = pattern_one; vecs[0].acc = pattern_one; vecs[0].ok = 1'b1;
    // lane powers of alpha
    vecs[1].n = 2; vecs[1].w[0] = 32'h00000001; vecs[1].w[1] = 32'h0;
    vecs[1].acc = 128'h00000008_00000004_00000002_00000001;
    vecs[1].tag = vecs[1].acc; vecs[1].ok = 1'b1;
    // reduction path, tag off by bit 0
    vecs[2].n = 2; vecs[2].w[0] = 32'h80000000; vecs[2].w[1] = 32'h0;
    vecs[2].acc = 128'h0100001C_0080000E_00400007_80000000;
    vecs[2].tag = vecs[2].acc ^ 128'h1; vecs[2].ok = 1'b0;
    // 8 random words gap-free, then the same words with random gaps
    vecs[3].n = 8; vecs[3].w = rw; vecs[3].acc = model(rw, 8);
    vecs[3].tag = vecs[3].acc; vecs[3].ok = 1'b1;
    vecs[4] = vecs[3]; vecs[4].gaps = 1'b1;
    // random words with gaps, tag off by the top bit
    for (int k = 0; k < 8; k++) vecs[5].w[k] = $urandom;
    vecs[5].n = 8; vecs[5].gaps = 1'b1; vecs[5].acc = model(vecs[5].w, 8);
    vecs[5].tag = vecs[5].acc ^ {1'b1, 127'h0}; vecs[5].ok = 1'b0;

    // reset state, checked while rst is still asserted
    #12;
    chk1("rst_ready", in_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_tag_ok", tag_ok, 1'b0);
    chk("rst_acc", tag_acc, 128'h0);
    @(negedge clk);
    rst = 1'b0;

    // in_valid in IDLE is ignored
    in_valid = 1'b1; in_data = 32'h5; in_last = 1'b1;
    repeat (3) @(negedge clk);
    chk1("idle_ready", in_ready, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk("idle_acc", tag_acc, 128'h0);
    chk("idle_no_done", 128'(done_cnt), 128'(0));
    in_valid = 1'b0; in_last = 1'b0;

    for (int v = 0; v < NV; v++) begin
      exp_acc_q.push_back(vecs[v].acc);
      exp_ok_q.push_back(vecs[v].ok);
      drive_stream(vecs[v].w, vecs[v].n, vecs[v].gaps, vecs[v].tag);
      wait_verdict($sformatf("vec%0d", v));
    end

    // abort: three beats, start again (with a beat that must be dropped),
    // then a one-word stream equal to vec0
    d0 = done_cnt;
    exp_acc_q.push_back(pattern_one);
    exp_ok_q.push_back(1'b1);
    @(negedge clk);
    start = 1'b1; tag_exp = pattern_one;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'h1234_5670 + 32'(k); in_last = 1'b0;
      @(negedge clk);
    end
    start = 1'b1; in_valid = 1'b1; in_data = 32'hcafef00d; in_last = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_acc_clear", tag_acc, 128'h0);
    chk1("abort_busy", busy, 1'b1);
    in_valid = 1'b1; in_data = 32'h1; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    wait_verdict("abort");
    @(negedge clk);
    chk("abort_single_done", 128'(done_cnt - d0), 128'(1));

    // asynchronous reset in the middle of ABSORB
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 32'h8000_0001 + 32'(k); in_last = 1'b0;
      @(negedge clk);
    end
    chk1("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_acc", tag_acc, 128'h0);
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_ready", in_ready, 1'b0);
    chk1("async_rst_done", done, 1'b0);
    chk1("async_rst_tag_ok", tag_ok, 1'b0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    chk("post_rst_no_done", 128'(done_cnt - d0), 128'(0));
    chk1("post_rst_idle", busy, 1'b0);
    chk("post_rst_queue_empty", 128'(exp_acc_q.size()), 128'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/v_tag_verify_32.md
Name: v_tag_verify_32

Overview:
- Receiver-side (decryption) tag checker for the 32-bit Vandermonde MAC.
- Absorbs a stream of 32-bit processed-data words (PDP) through a valid/ready handshake.
- Updates a 128-bit Horner accumulator with one word per accepted beat. Lane i is multiplied by alpha^i each step, then the word is XORed in.
- After the last word, compares the accumulator with the received tag and reports pass/fail. Sits between the decrypt datapath and the top-level release/discard logic.

Parameters:
- CONST_ALPHA_32, 32'h00400007, reduction polynomial for GF(2^32) (x^32 = x^22+x^2+x+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle pulse; clears the accumulator and enters ABSORB.
- in_valid  input  1  PDP word valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  32  PDP word.
- in_last  input  1  qualifies the final word of the stream.
- tag_exp  input  128  received tag; sampled in the CHECK state.
- busy  output  1  high in ABSORB or CHECK.
- done  output  1  one-cycle pulse, verdict valid.
- tag_ok  output  1  1 = accumulator equals tag_exp; held until next start.
- tag_acc  output  128  current accumulator; lane i = bits [32i+31:32i].

Behaviour:
- Reset values:
  - State IDLE.
  - Accumulator 0.
  - in_ready=0, busy=0, done=0, tag_ok=0.
- States and transitions:
  - IDLE: start -> ABSORB.
  - ABSORB: in_ready=1. A beat is accepted when in_valid && in_ready.
  - Accepted beat without in_last -> stay in ABSORB.
  - Accepted beat with in_last -> CHECK.
  - CHECK: in_ready=0. tag_ok <= (acc == tag_exp), then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Per-beat update, all lanes in the same cycle:
  - acc0 <= acc0 ^ d.
  - acc1 <= xa(acc1) ^ d.
  - acc2 <= xa(xa(acc2)) ^ d.
  - acc3 <= xa(xa(xa(acc3))) ^ d.
  - xa(v) = v[31] ? {v[30:0],0} ^ CONST_ALPHA_32 : {v[30:0],0}.
- Latency:
  - Last word accepted at edge N.
  - CHECK occupies the following cycle; tag_ok is registered at edge N+1.
  - done is high during cycle N+2.
  - Throughput: one word per cycle.
- start while in IDLE or DONE: clear acc, clear tag_ok, enter ABSORB. start has priority over done.
- start while in ABSORB or CHECK: abort. Clear acc, drop any beat presented that cycle, stay or return to ABSORB. No done pulse is issued for the aborted stream.
- in_valid outside ABSORB: ignored, no state change.
- in_last without in_valid: ignored.
- A stream of exactly one word is legal.
- Empty streams are not supported. start must be followed by at least one beat.
- tag_exp must be stable during CHECK only.
- Async rst mid-stream: everything returns to reset values immediately. No done pulse.
- The comparison is a full 128-bit equality evaluated in one cycle, with no early exit.

Optional Feature:
- Macro VTAG_ZEROIZE_EN.
- Defined: in the DONE cycle, the accumulator is cleared to 0 when tag_ok=0. tag_acc therefore never exposes the computed tag of a failed check. tag_acc reads 0 from cycle N+3 on.
- Not defined: the accumulator holds its final value until the next start or rst.

Decomposition:
- Shared package vtag_pkg:
  - CONST_ALPHA_32.
  - State encoding IDLE=2'd0, ABSORB=2'd1, CHECK=2'd2, DONE=2'd3.
  - Lane width 32 and lane count 4.
- One sub-module: gf32_xalpha, a combinational multiply-by-alpha.
  - Instantiated 6 times: 1 for lane 1, 2 chained for lane 2, 3 chained for lane 3.

Test Plan:
- start; one beat 0x00000001 with last; tag_exp=0x00000001_00000001_00000001_00000001 -> done at N+2, tag_ok=1.
- start; beats 0x00000001, then 0x00000000 with last -> tag_acc=0x00000008_00000004_00000002_00000001.
- start; beats 0x80000000, then 0x00000000 with last -> tag_acc=0x0100001C_0080000E_00400007_80000000; tag_exp differing in bit 0 -> tag_ok=0.
- Valid/ready stress: in_valid toggled randomly over 8 words; result must equal the gap-free run. in_ready=0 in CHECK/DONE/IDLE. Extra in_valid after last is ignored.
- Abort and reset:
  - start pulsed after 3 beats, then 1 beat 0x1 with last -> same result as scenario 1, with a single done pulse.
  - rst asserted mid-ABSORB -> outputs zero asynchronously, state IDLE.
- VTAG_ZEROIZE_EN builds:
  - Rerun scenario 3 -> tag_acc=0 after DONE.
  - Scenario 1 -> tag_acc retained.
